// File: rtl/matrix_scan_driver_pkg.sv
// ============================================================================
// matrix_scan_driver_pkg : shared geometry defaults, all-off drive constants,
//                          scan state type and clog2 helper
// Revision : 1.0
// ============================================================================
`default_nettype none

package matrix_scan_driver_pkg;

  localparam int DEFAULT_ROWS     = 8;
  localparam int DEFAULT_COLS     = 16;
  localparam int DEFAULT_PWM_BITS = 2;
  localparam int DEFAULT_DIV      = 1024;

  localparam int MAX_ROWS = 16;
  localparam int MAX_COLS = 32;

  // Active-low matrix: all ones means every row/column is released
  localparam logic [MAX_ROWS-1:0] MATRIX_ROW_OFF = '1;
  localparam logic [MAX_COLS-1:0] MATRIX_COL_OFF = '1;

  typedef enum logic [0:0] {
    SCAN_BLANK = 1'b0,
    SCAN_ON    = 1'b1
  } scan_state_e;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/matrix_scan_driver_tick_gen.sv
// ============================================================================
// tick_gen : free-running clock-enable generator, one-cycle tick every DIV clks
// Revision : 1.0
// ============================================================================
`default_nettype none

module tick_gen
  import matrix_scan_driver_pkg::*;
#(
  parameter int DIV = DEFAULT_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int              CW     = clog2(DIV);
  localparam logic [CW-1:0]   c_last = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = (cnt_q == c_last) ? '0 : cnt_q + CW'(1);
  end

  assign tick = (cnt_q == c_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/matrix_scan_driver.sv
// ============================================================================
// matrix_scan_driver : double-buffered active-low LED matrix scanner with
//                      blank-then-PWM row slots and frame-aligned buffer swap
// Revision : 1.0
// ============================================================================
`default_nettype none

module matrix_scan_driver
  import matrix_scan_driver_pkg::*;
#(
  parameter int ROWS     = DEFAULT_ROWS,
  parameter int COLS     = DEFAULT_COLS,
  parameter int DIV      = DEFAULT_DIV,
  parameter int PWM_BITS = DEFAULT_PWM_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [clog2(ROWS)-1:0] wr_row,
  input  logic [COLS-1:0]        wr_data,
  input  logic                   swap_req,
  input  logic [PWM_BITS:0]      brightness,
  output logic                   swap_pending,
  output logic                   frame_start,
  output logic [ROWS-1:0]        MATRIX_ROW,
  output logic [COLS-1:0]        MATRIX_COL
);

  localparam int                RW         = clog2(ROWS);
  localparam int                SW         = PWM_BITS + 1;
  localparam logic [SW-1:0]     c_nsub     = SW'(1 << PWM_BITS);
  localparam logic [RW-1:0]     c_last_row = RW'(ROWS - 1);
  localparam logic [RW:0]       c_rows     = (RW+1)'(ROWS);
  localparam logic [ROWS-1:0]   c_row_off  = MATRIX_ROW_OFF[ROWS-1:0];
  localparam logic [COLS-1:0]   c_col_off  = MATRIX_COL_OFF[COLS-1:0];
  localparam logic [ROWS-1:0]   c_row_one  = ROWS'(1);

  logic            tick;
  logic            boundary;
  logic [SW-1:0]   bright_clamped;

  scan_state_e     state_q,        state_d;
  logic [RW-1:0]   row_q,          row_d;
  logic [SW-1:0]   sub_q,          sub_d;
  logic            fb_q,           fb_d;
  logic            swap_pending_q, swap_pending_d;
  logic            frame_start_q,  frame_start_d;
  logic [ROWS-1:0] row_out_q,      row_out_d;
  logic [COLS-1:0] col_out_q,      col_out_d;
  logic [COLS-1:0] fbuf_q [2][ROWS];
  logic [COLS-1:0] fbuf_d [2][ROWS];

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_comb begin
    fbuf_d         = fbuf_q;
    state_d        = state_q;
    row_d          = row_q;
    sub_d          = sub_q;
    fb_d           = fb_q;
    swap_pending_d = swap_pending_q;
    row_out_d      = row_out_q;
    col_out_d      = col_out_q;

    bright_clamped = (brightness > c_nsub) ? c_nsub : brightness;
    boundary       = tick && (state_q == SCAN_ON) && (sub_q == c_nsub) && (row_q == c_last_row);

    // Write target uses the pre-edge select, so a write on a swapping
    // boundary lands in the buffer that is about to become front.
    if (wr_en && ({1'b0, wr_row} < c_rows)) begin
      fbuf_d[~fb_q][wr_row] = wr_data;
    end

    if (boundary) begin
      fb_d           = fb_q ^ (swap_pending_q | swap_req);
      swap_pending_d = 1'b0;
    end else begin
      swap_pending_d = swap_pending_q | swap_req;
    end
    frame_start_d = boundary;

    if (tick) begin
      case (state_q)
        SCAN_BLANK: begin
          state_d = SCAN_ON;
          sub_d   = SW'(1);
        end
        SCAN_ON: begin
          if (sub_q == c_nsub) begin
            state_d = SCAN_BLANK;
            sub_d   = '0;
            row_d   = (row_q == c_last_row) ? '0 : row_q + RW'(1);
          end else begin
            sub_d = sub_q + SW'(1);
          end
        end
        default: begin
          state_d = SCAN_BLANK;
          sub_d   = '0;
        end
      endcase

      if (state_d == SCAN_BLANK) begin
        row_out_d = c_row_off;
        col_out_d = c_col_off;
      end else begin
        row_out_d = ~(c_row_one << row_d);
        col_out_d = ((sub_d - SW'(1)) < bright_clamped) ? ~fbuf_q[fb_d][row_d] : c_col_off;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= SCAN_BLANK;
      row_q          <= '0;
      sub_q          <= '0;
      fb_q           <= 1'b0;
      swap_pending_q <= 1'b0;
      frame_start_q  <= 1'b0;
      row_out_q      <= c_row_off;
      col_out_q      <= c_col_off;
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          fbuf_q[b][r] <= '0;
        end
      end
    end else begin
      state_q        <= state_d;
      row_q          <= row_d;
      sub_q          <= sub_d;
      fb_q           <= fb_d;
      swap_pending_q <= swap_pending_d;
      frame_start_q  <= frame_start_d;
      row_out_q      <= row_out_d;
      col_out_q      <= col_out_d;
      fbuf_q         <= fbuf_d;
    end
  end

  assign swap_pending = swap_pending_q;
  assign frame_start  = frame_start_q;
  assign MATRIX_ROW   = row_out_q;
  assign MATRIX_COL   = col_out_q;

endmodule

`default_nettype wire

// File: tb/tb_matrix_scan_driver.sv
// ============================================================================
// tb_matrix_scan_driver : scenario bench for matrix_scan_driver against a
//                         frame-position reference model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_matrix_scan_driver;

  localparam int ROWS     = 6;
  localparam int COLS     = 16;
  localparam int DIV      = 4;
  localparam int PWM_BITS = 2;
  localparam int NSUB     = 1 << PWM_BITS;
  localparam int SL       = NSUB + 1;
  localparam int FRAME    = ROWS * SL * DIV;
  localparam int RW       = $clog2(ROWS);

  localparam logic [ROWS-1:0] ROW_OFF  = '1;
  localparam logic [COLS-1:0] COL_OFF  = '1;
  localparam logic [ROWS-1:0] ROW0_SEL = ~(ROWS'(1));
  localparam logic [ROWS-1:0] ROW3_SEL = ~(ROWS'(1) << 3);

  logic                clk = 1'b0;
  logic                reset;
  logic                wr_en;
  logic [RW-1:0]       wr_row;
  logic [COLS-1:0]     wr_data;
  logic                swap_req;
  logic [PWM_BITS:0]   brightness;
  logic                swap_pending;
  logic                frame_start;
  logic [ROWS-1:0]     MATRIX_ROW;
  logic [COLS-1:0]     MATRIX_COL;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: two frame buffers, front select, pending flag and
  // the number of clock edges since reset release.
  logic [COLS-1:0] m_buf [2][ROWS];
  logic            m_fb;
  logic            m_pend;
  int              ecount;
  logic [ROWS-1:0] exp_row;
  logic [COLS-1:0] exp_col;
  logic            exp_fs;
  logic            exp_pend;

  always #5 clk = ~clk;

  matrix_scan_driver #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .DIV      (DIV),
    .PWM_BITS (PWM_BITS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_row       (wr_row),
    .wr_data      (wr_data),
    .swap_req     (swap_req),
    .brightness   (brightness),
    .swap_pending (swap_pending),
    .frame_start  (frame_start),
    .MATRIX_ROW   (MATRIX_ROW),
    .MATRIX_COL   (MATRIX_COL)
  );

  task automatic model_update();
    int              pos;
    int              r;
    int              s;
    int              bc;
    bit              tick;
    bit              boundary;
    logic [ROWS-1:0] one;
    one = ROWS'(1);
    if (reset) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < ROWS; i++) m_buf[b][i] = '0;
      m_fb    = 1'b0;
      m_pend  = 1'b0;
      ecount  = 0;
      exp_row = ROW_OFF;
      exp_col = COL_OFF;
      exp_fs  = 1'b0;
    end else begin
      tick     = ((ecount % DIV) == DIV - 1);
      boundary = tick && (((ecount + 1) % FRAME) == 0);
      pos      = ((ecount + 1) / DIV) % (ROWS * SL);
      ecount++;
      if (wr_en && (int'(wr_row) < ROWS)) m_buf[!m_fb][wr_row] = wr_data;
      if (boundary) begin
        if (m_pend || swap_req) m_fb = !m_fb;
        m_pend = 1'b0;
      end else if (swap_req) begin
        m_pend = 1'b1;
      end
      exp_fs = boundary;
      if (tick) begin
        r = pos / SL;
        s = pos % SL;
        if (s == 0) begin
          exp_row = ROW_OFF;
          exp_col = COL_OFF;
        end else begin
          bc      = (int'(brightness) > NSUB) ? NSUB : int'(brightness);
          exp_row = ~(one << r);
          exp_col = ((s - 1) < bc) ? ~m_buf[m_fb][r] : COL_OFF;
        end
      end
    end
    exp_pend = m_pend;
  endtask

  // Inputs change on negedge; model and DUT both sample them on posedge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  // Step until the next posedge is d edges ahead of a frame boundary edge.
  task automatic advance_to(input int d, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < FRAME + 2; k++) begin
      if ((FRAME - 1 - (ecount % FRAME)) == d) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    n_checks++; if (MATRIX_ROW !== ROW_OFF) $display("FAIL reset_row: got %h exp %h", MATRIX_ROW, ROW_OFF); else n_pass++;
    n_checks++; if (MATRIX_COL !== COL_OFF) $display("FAIL reset_col: got %h exp %h", MATRIX_COL, COL_OFF); else n_pass++;
    n_checks++; if (swap_pending !== 1'b0) $display("FAIL reset_pending: got %b exp 0", swap_pending); else n_pass++;
    n_checks++; if (frame_start !== 1'b0) $display("FAIL reset_fs: got %b exp 0", frame_start); else n_pass++;
    reset = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      n_checks++;
      if ({MATRIX_ROW, MATRIX_COL, frame_start, swap_pending} !== {exp_row, exp_col, exp_fs, exp_pend})
        $display("FAIL reset_frame cyc %0d: got row=%h col=%h fs=%b pend=%b exp row=%h col=%h fs=%b pend=%b",
                 i, MATRIX_ROW, MATRIX_COL, frame_start, swap_pending, exp_row, exp_col, exp_fs, exp_pend);
      else n_pass++;
    end
  endtask

  task automatic test_display();
    bit ok;
    int lit;
    brightness = 3'd4;
    wr_en = 1'b1; wr_row = RW'(3); wr_data = 16'hA5A5;
    step();
    wr_en = 1'b0; swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    n_checks++; if (swap_pending !== 1'b1) $display("FAIL display_pending: got %b exp 1", swap_pending); else n_pass++;
    advance_to(0, ok);
    n_checks++; if (!ok) $display("FAIL display_align: got timeout exp boundary"); else n_pass++;
    step();
    lit = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (MATRIX_ROW === ROW3_SEL && MATRIX_COL === 16'h5A5A) lit++;
      n_checks++;
      if ({MATRIX_ROW, MATRIX_COL, frame_start, swap_pending} !== {exp_row, exp_col, exp_fs, exp_pend})
        $display("FAIL display_frame cyc %0d: got row=%h col=%h fs=%b pend=%b exp row=%h col=%h fs=%b pend=%b",
                 i, MATRIX_ROW, MATRIX_COL, frame_start, swap_pending, exp_row, exp_col, exp_fs, exp_pend);
      else n_pass++;
    end
    n_checks++; if (lit !== NSUB * DIV) $display("FAIL display_lit: got %0d exp %0d", lit, NSUB * DIV); else n_pass++;
  endtask

  task automatic test_brightness();
    int levels [4];
    int lit;
    int want;
    levels[0] = 1; levels[1] = 0; levels[2] = 7; levels[3] = int'($urandom_range(0, 7));
    for (int b = 0; b < 4; b++) begin
      brightness = PWM_BITS'(0) + (PWM_BITS+1)'(levels[b]);
      want = ((levels[b] > NSUB) ? NSUB : levels[b]) * DIV;
      lit = 0;
      for (int i = 0; i < SL * DIV + FRAME; i++) begin
        step();
        if (i >= SL * DIV && MATRIX_ROW === ROW3_SEL && MATRIX_COL === 16'h5A5A) lit++;
        n_checks++;
        if ({MATRIX_ROW, MATRIX_COL, frame_start, swap_pending} !== {exp_row, exp_col, exp_fs, exp_pend})
          $display("FAIL bright%0d cyc %0d: got row=%h col=%h fs=%b pend=%b exp row=%h col=%h fs=%b pend=%b",
                   levels[b], i, MATRIX_ROW, MATRIX_COL, frame_start, swap_pending, exp_row, exp_col, exp_fs, exp_pend);
        else n_pass++;
      end
      n_checks++;
      if (lit !== want) $display("FAIL bright%0d_lit: got %0d exp %0d", levels[b], lit, want); else n_pass++;
    end
    brightness = 3'd4;
  endtask

  task automatic test_swap_boundary();
    bit              ok;
    int              fs_cnt;
    logic [COLS-1:0] x;
    for (int r = 1; r < ROWS; r++) begin
      wr_en = 1'b1; wr_row = RW'(r); wr_data = COLS'($urandom);
      step();
    end
    wr_en = 1'b0;
    advance_to(10, ok);
    n_checks++; if (!ok) $display("FAIL swapb_align10: got timeout exp boundary"); else n_pass++;
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    n_checks++; if (swap_pending !== 1'b1) $display("FAIL swapb_pending: got %b exp 1", swap_pending); else n_pass++;
    advance_to(0, ok);
    x = COLS'($urandom) | COLS'(1);
    wr_en = 1'b1; wr_row = '0; wr_data = x;
    step();
    wr_en = 1'b0;
    n_checks++; if (frame_start !== 1'b1) $display("FAIL swapb_fs: got %b exp 1", frame_start); else n_pass++;
    n_checks++; if (swap_pending !== 1'b0) $display("FAIL swapb_clear: got %b exp 0", swap_pending); else n_pass++;
    fs_cnt = 0;
    for (int i = 0; i < FRAME - 1; i++) begin
      step();
      if (frame_start === 1'b1) fs_cnt++;
      if (i == DIV - 1) begin
        n_checks++;
        if (MATRIX_ROW !== ROW0_SEL || MATRIX_COL !== ~x)
          $display("FAIL swapb_row0: got row=%h col=%h exp row=%h col=%h", MATRIX_ROW, MATRIX_COL, ROW0_SEL, ~x);
        else n_pass++;
      end
      n_checks++;
      if ({MATRIX_ROW, MATRIX_COL, frame_start, swap_pending} !== {exp_row, exp_col, exp_fs, exp_pend})
        $display("FAIL swapb_frame cyc %0d: got row=%h col=%h fs=%b pend=%b exp row=%h col=%h fs=%b pend=%b",
                 i, MATRIX_ROW, MATRIX_COL, frame_start, swap_pending, exp_row, exp_col, exp_fs, exp_pend);
      else n_pass++;
    end
    n_checks++; if (fs_cnt !== 0) $display("FAIL swapb_fs_once: got %0d extra pulses exp 0", fs_cnt); else n_pass++;
    // swap request arriving exactly on the boundary cycle
    advance_to(0, ok);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    n_checks++; if (frame_start !== 1'b1) $display("FAIL swapb_on_fs: got %b exp 1", frame_start); else n_pass++;
    n_checks++; if (swap_pending !== 1'b0) $display("FAIL swapb_on_pending: got %b exp 0", swap_pending); else n_pass++;
    for (int i = 0; i < FRAME; i++) begin
      step();
      n_checks++;
      if ({MATRIX_ROW, MATRIX_COL, frame_start, swap_pending} !== {exp_row, exp_col, exp_fs, exp_pend})
        $display("FAIL swapb_on_frame cyc %0d: got row=%h col=%h fs=%b pend=%b exp row=%h col=%h fs=%b pend=%b",
                 i, MATRIX_ROW, MATRIX_COL, frame_start, swap_pending, exp_row, exp_col, exp_fs, exp_pend);
      else n_pass++;
    end
  endtask

  task automatic test_invalid_and_double();
    bit ok;
    advance_to(FRAME - 20, ok);
    n_checks++; if (!ok) $display("FAIL inv_align: got timeout exp boundary"); else n_pass++;
    wr_en = 1'b1; wr_row = RW'(6); wr_data = 16'hFFFF;
    step();
    wr_row = RW'(7); wr_data = 16'h1234;
    step();
    wr_row = RW'(2); wr_data = 16'h0FF0;
    step();
    wr_en = 1'b0; swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    repeat (7) step();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    n_checks++; if (swap_pending !== 1'b1) $display("FAIL inv_pending: got %b exp 1", swap_pending); else n_pass++;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      n_checks++;
      if ({MATRIX_ROW, MATRIX_COL, frame_start, swap_pending} !== {exp_row, exp_col, exp_fs, exp_pend})
        $display("FAIL inv_frame cyc %0d: got row=%h col=%h fs=%b pend=%b exp row=%h col=%h fs=%b pend=%b",
                 i, MATRIX_ROW, MATRIX_COL, frame_start, swap_pending, exp_row, exp_col, exp_fs, exp_pend);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int dark_bad;
    advance_to(30, ok);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    advance_to(8, ok);
    n_checks++; if (!ok) $display("FAIL rmid_align: got timeout exp boundary"); else n_pass++;
    n_checks++; if (MATRIX_ROW !== ~(ROWS'(1) << 5)) $display("FAIL rmid_row5: got %h exp %h", MATRIX_ROW, ~(ROWS'(1) << 5)); else n_pass++;
    n_checks++; if (swap_pending !== 1'b1) $display("FAIL rmid_pending_before: got %b exp 1", swap_pending); else n_pass++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if (MATRIX_ROW !== ROW_OFF) $display("FAIL rmid_row: got %h exp %h", MATRIX_ROW, ROW_OFF); else n_pass++;
    n_checks++; if (MATRIX_COL !== COL_OFF) $display("FAIL rmid_col: got %h exp %h", MATRIX_COL, COL_OFF); else n_pass++;
    n_checks++; if (swap_pending !== 1'b0) $display("FAIL rmid_pending: got %b exp 0", swap_pending); else n_pass++;
    dark_bad = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (MATRIX_COL !== COL_OFF) dark_bad++;
      if (i == DIV - 1) begin
        n_checks++;
        if (MATRIX_ROW !== ROW0_SEL) $display("FAIL rmid_restart: got %h exp %h", MATRIX_ROW, ROW0_SEL); else n_pass++;
      end
      n_checks++;
      if ({MATRIX_ROW, MATRIX_COL, frame_start, swap_pending} !== {exp_row, exp_col, exp_fs, exp_pend})
        $display("FAIL rmid_frame cyc %0d: got row=%h col=%h fs=%b pend=%b exp row=%h col=%h fs=%b pend=%b",
                 i, MATRIX_ROW, MATRIX_COL, frame_start, swap_pending, exp_row, exp_col, exp_fs, exp_pend);
      else n_pass++;
    end
    n_checks++; if (dark_bad !== 0) $display("FAIL rmid_dark: got %0d lit cycles exp 0", dark_bad); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 4 * FRAME; i++) begin
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_row   = RW'($urandom_range(0, 7));
      wr_data  = COLS'($urandom);
      swap_req = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 59) == 0) brightness = (PWM_BITS+1)'($urandom_range(0, 7));
      step();
      n_checks++;
      if ({MATRIX_ROW, MATRIX_COL, frame_start, swap_pending} !== {exp_row, exp_col, exp_fs, exp_pend})
        $display("FAIL random cyc %0d: got row=%h col=%h fs=%b pend=%b exp row=%h col=%h fs=%b pend=%b",
                 i, MATRIX_ROW, MATRIX_COL, frame_start, swap_pending, exp_row, exp_col, exp_fs, exp_pend);
      else n_pass++;
    end
    wr_en = 1'b0;
    swap_req = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    wr_en      = 1'b0;
    wr_row     = '0;
    wr_data    = '0;
    swap_req   = 1'b0;
    brightness = 3'd4;
    @(negedge clk);
    test_reset();
    test_display();
    test_brightness();
    test_swap_boundary();
    test_invalid_and_double();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
